pipelined_adder: RTL and testbench

Parametrised successor to the team's 2-bit registered adder. Adds or subtracts two WIDTH-bit operands through a carry-pipelined datapath split into CHUNK-bit stages, so wide adds close timing at the target clock. Provides a valid/ready handshake on both sides, full-pipeline backpressure, and carry and signed-overflow outputs. Used as the arithmetic leaf in the datapath wherever the plain registered adder is too narrow or too slow.

---
 rtl/pipelined_adder_if.sv | 42 ++++
 rtl/pipelined_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_adder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Groups the operand-side and result-side valid/ready handshakes of
// pipelined_adder into one bundle.
//
// Signals:
//   in_valid   producer presents a, b, sub this cycle
//   in_ready   adder accepts the presented operands this cycle
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   sub        0: a+b, 1: a-b
//   out_valid  s and ovf hold a result
//   out_ready  consumer takes the result this cycle
//   s          {carry_out, sum}, WIDTH+1 bits
//   ovf        signed two's-complement overflow of the sum
//
// Modports:
//   slave  - the adder's view
//   master - the view of whoever drives operands and consumes results
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, ovf
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Carry-pipelined WIDTH-bit adder/subtractor. The operands are split into
// STAGES = WIDTH/CHUNK chunks; stage k resolves sum bits [k*CHUNK +: CHUNK]
// using the carry registered by stage k-1 (stage 0 uses sub as carry-in).
// Latency is STAGES cycles, throughput one result per cycle, with a global
// stall driven by the output handshake.
//
// Parameters:
//   WIDTH  operand width, >= 2 and a multiple of CHUNK
//   CHUNK  bits resolved per pipeline stage
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears every register
//   bus    pipelined_adder_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Registered state of the final stage, exported out of the generate loop.
    logic             last_valid;
    logic             last_carry;
    logic [WIDTH-1:0] last_sum;
    logic             last_a_msb;
    logic             last_b_msb;

    // One global advance: the whole pipeline moves or the whole pipeline holds.
    logic advance;
    assign advance = bus.out_ready || !last_valid;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Operand bits still unresolved when entering this stage.
        localparam int W_IN = WIDTH - gi * CHUNK;

        logic [W_IN-1:0]         a_in;
        logic [W_IN-1:0]         b_in;
        logic                    c_in;
        logic                    v_in;
        logic                    a_msb_in;
        logic                    b_msb_in;
        logic [CHUNK:0]          chunk_d;
        logic [(gi+1)*CHUNK-1:0] sum_d;

        logic                    valid_q;
        logic                    carry_q;
        logic [(gi+1)*CHUNK-1:0] sum_q;
        logic                    a_msb_q;
        logic                    b_msb_q;

        if (gi == 0) begin : g_head
            // Subtraction is a + ~b + 1: invert b here and feed sub as carry-in.
            assign a_in     = bus.a;
            assign b_in     = bus.sub ? ~bus.b : bus.b;
            assign c_in     = bus.sub;
            assign v_in     = bus.in_valid;
            assign a_msb_in = bus.a[WIDTH-1];
            assign b_msb_in = b_in[W_IN-1];
            assign sum_d    = chunk_d[CHUNK-1:0];
        end else begin : g_body
            assign a_in     = g_stage[gi-1].g_ops.a_rest_q;
            assign b_in     = g_stage[gi-1].g_ops.b_rest_q;
            assign c_in     = g_stage[gi-1].carry_q;
            assign v_in     = g_stage[gi-1].valid_q;
            assign a_msb_in = g_stage[gi-1].a_msb_q;
            assign b_msb_in = g_stage[gi-1].b_msb_q;
            assign sum_d    = {chunk_d[CHUNK-1:0], g_stage[gi-1].sum_q};
        end

        // One CHUNK-bit slice of the add, carry-out in the top bit.
        assign chunk_d = {1'b0, a_in[CHUNK-1:0]}
                       + {1'b0, b_in[CHUNK-1:0]}
                       + (CHUNK+1)'(c_in);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
            end else if (advance) begin
                valid_q <= v_in;
                carry_q <= chunk_d[CHUNK];
                sum_q   <= sum_d;
                a_msb_q <= a_msb_in;
                b_msb_q <= b_msb_in;
            end
        end

        // Upper operand chunks not yet consumed ride along with the partial sum.
        if (gi < STAGES - 1) begin : g_ops
            logic [W_IN-CHUNK-1:0] a_rest_q;
            logic [W_IN-CHUNK-1:0] b_rest_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_rest_q <= '0;
                    b_rest_q <= '0;
                end else if (advance) begin
                    a_rest_q <= a_in[W_IN-1:CHUNK];
                    b_rest_q <= b_in[W_IN-1:CHUNK];
                end
            end
        end

        if (gi == STAGES - 1) begin : g_tail
            assign last_valid = valid_q;
            assign last_carry = carry_q;
            assign last_sum   = sum_q;
            assign last_a_msb = a_msb_q;
            assign last_b_msb = b_msb_q;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = last_valid;
    assign bus.s         = {last_carry, last_sum};
    // Overflow from registered sign bits only, so no path from a/b to ovf.
    assign bus.ovf       = (last_a_msb == last_b_msb) && (last_sum[WIDTH-1] != last_a_msb);
endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
    localparam int W  = 8;
    localparam int C  = 4;
    localparam int ST = W / C;
    localparam int W2 = 2;
    localparam int C2 = 2;

    typedef struct {
        logic         valid;
        logic [W:0]   s;
        logic         ovf;
    } slot_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W))  bus ();
    pipelined_adder_if #(.WIDTH(W2)) bus2 ();

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipelined_adder #(.WIDTH(W2), .CHUNK(C2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a delay line of STAGES result slots with a global stall.
    slot_t      pipe_m [ST];
    logic [W:0] drained_s [$];
    logic       drained_ovf [$];

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        int unsigned ua = a;
        int unsigned ub = b;
        // a - b shifted up by 2^W: bit W is set exactly when no borrow occurs.
        if (sub) return (W+1)'(ua + (1 << W) - ub);
        return (W+1)'(ua + ub);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub);
        int sa = $signed(a);
        int sb = $signed(b);
        int r  = sub ? (sa - sb) : (sa + sb);
        return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
    endfunction

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < ST; i++) pipe_m[i] = '{valid: 1'b0, s: '0, ovf: 1'b0};
    endtask

    // One clock cycle on the wide adder: drive, check at negedge, update model.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ordy, output logic accepted);
        logic adv;
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = sub;
        bus.out_ready = ordy;
        @(negedge clk);
        adv = ordy || !pipe_m[ST-1].valid;
        check("in_ready", {8'd0, bus.in_ready}, {8'd0, adv});
        check("out_valid", {8'd0, bus.out_valid}, {8'd0, pipe_m[ST-1].valid});
        if (pipe_m[ST-1].valid) begin
            check("s", bus.s, pipe_m[ST-1].s);
            check("ovf", {8'd0, bus.ovf}, {8'd0, pipe_m[ST-1].ovf});
            if (ordy) begin
                drained_s.push_back(bus.s);
                drained_ovf.push_back(bus.ovf);
            end
        end
        accepted = v && adv;
        @(posedge clk);
        #1;
        if (adv) begin
            for (int i = ST - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
            pipe_m[0] = '{valid: v, s: ref_sum(a, b, sub), ovf: ref_ovf(a, b, sub)};
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    // Single beat on the 2-bit adder: nothing before the edge, result after it.
    task automatic deg_beat(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic sub);
        int          r;
        logic [W2:0] exp_s;
        logic        exp_o;
        exp_s = sub ? (W2+1)'(int'(a) + 4 - int'(b)) : (W2+1)'(int'(a) + int'(b));
        r     = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
        exp_o = (r < -2) || (r > 1);
        bus2.in_valid = 1'b1;
        bus2.a        = a;
        bus2.b        = b;
        bus2.sub      = sub;
        @(negedge clk);
        check("deg_pre_valid", {8'd0, bus2.out_valid}, 9'd0);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("deg_valid", {8'd0, bus2.out_valid}, 9'd1);
        check("deg_s", {6'd0, bus2.s}, {6'd0, exp_s});
        check("deg_ovf", {8'd0, bus2.ovf}, {8'd0, exp_o});
        $display("deg a=%0d b=%0d sub=%0d -> s=%b ovf=%0d", a, b, sub, bus2.s, bus2.ovf);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] bb_a   [5] = '{8'd255, 8'd127, 8'd5, 8'd3, 8'h80};
    logic [W-1:0] bb_b   [5] = '{8'd1,   8'd1,   8'd3, 8'd5, 8'd1};
    logic         bb_sub [5] = '{1'b0,   1'b0,   1'b1, 1'b1, 1'b1};
    logic [W:0]   bb_s   [5] = '{9'h100, 9'h080, 9'h102, 9'h0FE, 9'h17F};
    logic         bb_o   [5] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1};

    initial begin
        logic acc;
        logic [W-1:0] pend [$];
        int t;

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.sub       = 1'b0;
        bus2.out_ready = 1'b1;
        clear_model();

        // Reset state
        #1;
        check("rst_out_valid", {8'd0, bus.out_valid}, 9'd0);
        check("rst_s", bus.s, 9'd0);
        check("rst_ovf", {8'd0, bus.ovf}, 9'd0);
        check("rst_in_ready", {8'd0, bus.in_ready}, 9'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single beat 1+1: visible exactly ST edges later, for one cycle
        drained_s.delete();
        drained_ovf.delete();
        cycle(1'b1, 8'd1, 8'd1, 1'b0, 1'b1, acc);
        idle(4);
        check("first_count", 9'(drained_s.size()), 9'd1);
        if (drained_s.size() > 0) check("first_s", drained_s[0], 9'h002);
        $display("single beat 1+1 drained %0d result(s)", drained_s.size());

        // Back-to-back directed beats
        drained_s.delete();
        drained_ovf.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, bb_a[i], bb_b[i], bb_sub[i], 1'b1, acc);
        idle(ST + 1);
        check("b2b_count", 9'(drained_s.size()), 9'd5);
        for (int i = 0; i < 5 && i < drained_s.size(); i++) begin
            check("b2b_s", drained_s[i], bb_s[i]);
            check("b2b_ovf", {8'd0, drained_ovf[i]}, {8'd0, bb_o[i]});
            $display("b2b #%0d s=%h ovf=%0d", i, drained_s[i], drained_ovf[i]);
        end

        // Backpressure: out_ready low for 3 cycles starting at first out_valid
        drained_s.delete();
        drained_ovf.delete();
        pend = '{8'd1, 8'd2, 8'd3, 8'd4};
        t = 0;
        while ((pend.size() > 0 || t < 12) && t < 40) begin
            if (pend.size() > 0)
                cycle(1'b1, pend[0], 8'd0, 1'b0, !(t >= ST && t < ST + 3), acc);
            else
                cycle(1'b0, 8'd0, 8'd0, 1'b0, !(t >= ST && t < ST + 3), acc);
            if (acc) void'(pend.pop_front());
            t++;
        end
        check("bp_pending", 9'(pend.size()), 9'd0);
        check("bp_count", 9'(drained_s.size()), 9'd4);
        for (int i = 0; i < 4 && i < drained_s.size(); i++) begin
            check("bp_order", drained_s[i], 9'(i + 1));
            $display("backpressure #%0d s=%h", i, drained_s[i]);
        end

        // Bubbles: valid pattern 1,0,1
        drained_s.delete();
        drained_ovf.delete();
        cycle(1'b1, 8'd10, 8'd20, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd30, 8'd40, 1'b0, 1'b1, acc);
        idle(ST + 1);
        check("bub_count", 9'(drained_s.size()), 9'd2);
        if (drained_s.size() == 2) begin
            check("bub_s0", drained_s[0], 9'h01E);
            check("bub_s1", drained_s[1], 9'h046);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, acc);
        end
        idle(ST + 1);
        $display("random phase done, %0d vectors so far", vectors);

        // Reset mid-flight
        cycle(1'b1, 8'd7, 8'd8, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd9, 8'd9, 1'b0, 1'b1, acc);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", {8'd0, bus.out_valid}, 9'd0);
        check("mid_rst_s", bus.s, 9'd0);
        check("mid_rst_in_ready", {8'd0, bus.in_ready}, 9'd1);
        bus.in_valid = 1'b1;
        bus.a        = 8'd55;
        bus.b        = 8'd66;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_rst_out_valid", {8'd0, bus.out_valid}, 9'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        idle(4);
        $display("reset mid-flight checked");

        // Degenerate single-stage adder
        deg_beat(2'd1, 2'd1, 1'b0);
        deg_beat(2'd2, 2'd3, 1'b0);
        deg_beat(2'd0, 2'd1, 1'b1);
        for (int i = 0; i < 32; i++) deg_beat(2'(i), 2'(i >> 2), 1'(i >> 4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
